booth_divider: RTL



---
 rtl/booth_divider.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/booth_divider.sv
// booth_divider: sequential signed restoring divider.
// Operands are converted to magnitudes on accept, divided one quotient bit per
// clock, then sign-corrected so that the quotient truncates toward zero and the
// remainder takes the sign of the dividend. Latency is fixed at WIDTH+1 edges
// (1 edge for a zero divisor), so callers can schedule around it statically.
module booth_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Control and datapath state
    state_t           state_q,       state_d;
    logic             neg_quo_q,     neg_quo_d;     // quotient must be negated in FIX
    logic             neg_rem_q,     neg_rem_d;     // remainder must be negated in FIX
    logic             zero_q,        zero_d;        // current operation has divisor == 0
    logic             ovf_pend_q,    ovf_pend_d;    // current operation is MIN / -1
    logic [WIDTH-1:0] dvs_q,         dvs_d;         // |divisor|
    logic [WIDTH:0]   rem_q,         rem_d;         // partial remainder
    logic [WIDTH-1:0] dq_q,          dq_d;          // dividend shifting out / quotient shifting in
    logic [CW-1:0]    count_q,       count_d;

    // Registered outputs
    logic [WIDTH-1:0] quotient_q,    quotient_d;
    logic [WIDTH-1:0] remainder_q,   remainder_d;
    logic             busy_q,        busy_d;
    logic             done_q,        done_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             ovf_q,         ovf_d;

    // Helper values
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] min_val;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_signed;

    // Magnitudes of the operands; |MIN| = 2^(WIDTH-1) is representable unsigned.
    assign dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? (~divisor  + 1'b1) : divisor;
    assign min_val      = {1'b1, {(WIDTH-1){1'b0}}};

    // One restoring step: bring the next dividend bit into the remainder and
    // try subtracting the divisor. Both operands are below 2^WIDTH, so the top
    // bit of the WIDTH+1-bit difference is a valid borrow/sign indicator.
    assign shifted = {rem_q[WIDTH-1:0], dq_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    // Remainder with the dividend's sign applied (also reproduces the raw
    // dividend in the divide-by-zero case, where rem holds |dividend|).
    assign rem_signed = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

    // Next-state and next-output logic for the IDLE -> CALC -> FIX sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; an unassigned path in always_comb infers a latch.
        state_d       = state_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        zero_d        = zero_q;
        ovf_pend_d    = ovf_pend_q;
        dvs_d         = dvs_q;
        rem_d         = rem_q;
        dq_d          = dq_q;
        count_d       = count_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;
        ovf_d         = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    neg_quo_d     = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_rem_d     = dividend[WIDTH-1];
                    zero_d        = (divisor == '0);
                    ovf_pend_d    = (dividend == min_val) && (divisor == '1);
                    dvs_d         = divisor_mag;
                    dq_d          = dividend_mag;
                    rem_d         = '0;
                    count_d       = CW'(WIDTH);
                    busy_d        = 1'b1;
                    div_by_zero_d = 1'b0;
                    ovf_d         = 1'b0;
                    if (divisor == '0) begin
                        // Keep |dividend| in rem so FIX can rebuild the dividend.
                        rem_d   = {1'b0, dividend_mag};
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                if (trial[WIDTH]) begin
                    rem_d = shifted;
                    dq_d  = {dq_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial;
                    dq_d  = {dq_q[WIDTH-2:0], 1'b1};
                end
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                remainder_d = rem_signed;
                if (zero_q) begin
                    quotient_d    = '1;
                    div_by_zero_d = 1'b1;
                    ovf_d         = 1'b0;
                end else begin
                    // MIN / -1 naturally wraps to MIN here; only the flag differs.
                    quotient_d    = neg_quo_q ? (~dq_q + 1'b1) : dq_q;
                    div_by_zero_d = 1'b0;
                    ovf_d         = ovf_pend_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            zero_q        <= 1'b0;
            ovf_pend_q    <= 1'b0;
            dvs_q         <= '0;
            rem_q         <= '0;
            dq_q          <= '0;
            count_q       <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q       <= state_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            zero_q        <= zero_d;
            ovf_pend_q    <= ovf_pend_d;
            dvs_q         <= dvs_d;
            rem_q         <= rem_d;
            dq_q          <= dq_d;
            count_q       <= count_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
            ovf_q         <= ovf_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign ovf         = ovf_q;

endmodule
